// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//
// General-purpose integer register file for the RISC-V core: NUM_REGS entries
// of DATA_WIDTH bits, two combinational read ports, one synchronous write port.
// Register x0 is hardwired to zero. A write that is being presented in the
// current cycle is forwarded to any read port addressing the same register, so
// decode sees write-back data without waiting for the clock edge.
//
// Ports:
//   clk  in   system clock; writes occur on the rising edge
//   rst  in   asynchronous, active-high reset; clears every register
//   rr1  in   read port 1 register index
//   rr2  in   read port 2 register index
//   wr   in   write register index
//   wd   in   write data
//   wen  in   write enable, active-high
//   rd1  out  read data, port 1
//   rd2  out  read data, port 2
//
// NUM_REGS must equal 2**ADDR_WIDTH; every index value is then a valid entry.
// -----------------------------------------------------------------------------
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rr1,
    input  logic [ADDR_WIDTH-1:0] rr2,
    input  logic [ADDR_WIDTH-1:0] wr,
    input  logic [DATA_WIDTH-1:0] wd,
    input  logic                  wen,
    output logic [DATA_WIDTH-1:0] rd1,
    output logic [DATA_WIDTH-1:0] rd2
);

    // Entry 0 is kept in the array so every index maps directly, but it is
    // never written and therefore stays at its reset value of zero.
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    // A write is live only when enabled, out of reset and not aimed at x0.
    logic write_live;
    assign write_live = wen && !rst && (wr != '0);

    always_comb begin
        regs_d = regs_q;
        if (write_live) begin
            regs_d[wr] = wd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read priority: reset forces zero, x0 is zero, an in-flight write to the
    // same index is forwarded, otherwise the stored value is returned. The
    // forwarded value equals what is stored at the edge, so the port output
    // does not glitch across the write.
    always_comb begin
        rd1 = regs_q[rr1];
        if (rst || (rr1 == '0)) begin
            rd1 = '0;
        end else if (write_live && (rr1 == wr)) begin
            rd1 = wd;
        end
    end

    always_comb begin
        rd2 = regs_q[rr2];
        if (rst || (rr2 == '0)) begin
            rd2 = '0;
        end else if (write_live && (rr2 == wr)) begin
            rd2 = wd;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Testbench for register_file: table of directed vectors plus hand-written
// sequences for hold, bypass-across-edge, async reset and a full sweep.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic [4:0]  rr1;
  logic [4:0]  rr2;
  logic [4:0]  wr;
  logic [31:0] wd;
  logic        wen;
  logic [31:0] rd1;
  logic [31:0] rd2;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];

  register_file #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5),
    .NUM_REGS(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rr1(rr1),
    .rr2(rr2),
    .wr(wr),
    .wd(wd),
    .wen(wen),
    .rd1(rd1),
    .rd2(rd2)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic drive(input logic w_en, input logic [4:0] w_r, input logic [31:0] w_d,
                       input logic [4:0] r1, input logic [4:0] r2);
    wen = w_en;
    wr  = w_r;
    wd  = w_d;
    rr1 = r1;
    rr2 = r2;
  endtask

  // scoreboard compare
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // compare against the head of the expected queue
  task automatic check_q(input string name, input logic [31:0] act);
    logic [31:0] exp;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: expected queue empty, got 0x%08h", name, act);
    end else begin
      exp = exp_q.pop_front();
      check(name, act, exp);
    end
  endtask

  typedef struct {
    logic        wen;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];
  logic [31:0] model[32];

  initial begin
    // Expected values are the pre-edge read data in each cycle; the write in
    // a vector commits at the posedge that ends that cycle.
    vecs[0]  = '{1'b1, 5'd1,  32'h0000000A, 5'd1,  5'd2,  32'h0000000A, 32'h00000000};
    vecs[1]  = '{1'b1, 5'd2,  32'h0000000B, 5'd1,  5'd2,  32'h0000000A, 32'h0000000B};
    vecs[2]  = '{1'b0, 5'd0,  32'h00000000, 5'd1,  5'd2,  32'h0000000A, 32'h0000000B};
    vecs[3]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h00000000, 32'h00000000};
    vecs[4]  = '{1'b0, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd1,  32'h00000000, 32'h0000000A};
    vecs[5]  = '{1'b1, 5'd3,  32'h12345678, 5'd3,  5'd3,  32'h12345678, 32'h12345678};
    vecs[6]  = '{1'b0, 5'd3,  32'hDEADBEEF, 5'd3,  5'd3,  32'h12345678, 32'h12345678};
    vecs[7]  = '{1'b0, 5'd3,  32'hDEADBEEF, 5'd3,  5'd2,  32'h12345678, 32'h0000000B};
    vecs[8]  = '{1'b0, 5'd3,  32'hDEADBEEF, 5'd3,  5'd3,  32'h12345678, 32'h12345678};
    vecs[9]  = '{1'b1, 5'd5,  32'hCAFEF00D, 5'd5,  5'd5,  32'hCAFEF00D, 32'hCAFEF00D};
    vecs[10] = '{1'b0, 5'd0,  32'h00000000, 5'd5,  5'd3,  32'hCAFEF00D, 32'h12345678};
    vecs[11] = '{1'b1, 5'd5,  32'h11111111, 5'd5,  5'd6,  32'h11111111, 32'h00000000};
    vecs[12] = '{1'b1, 5'd5,  32'h22222222, 5'd5,  5'd5,  32'h22222222, 32'h22222222};
    vecs[13] = '{1'b0, 5'd5,  32'h33333333, 5'd5,  5'd1,  32'h22222222, 32'h0000000A};
    vecs[14] = '{1'b1, 5'd31, 32'h80000001, 5'd31, 5'd30, 32'h80000001, 32'h00000000};
    vecs[15] = '{1'b0, 5'd0,  32'h00000000, 5'd31, 5'd1,  32'h80000001, 32'h0000000A};

    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
    #12;
    check("reset rd1", rd1, 32'h0);
    check("reset rd2", rd2, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // table-driven vectors
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].wen, vecs[i].wr, vecs[i].wd, vecs[i].rr1, vecs[i].rr2);
      #1;
      check($sformatf("vec%0d rd1", i), rd1, vecs[i].e1);
      check($sformatf("vec%0d rd2", i), rd2, vecs[i].e2);
    end

    // hold with wen=0 for 100 ns
    @(negedge clk);
    drive(1'b0, 5'd1, 32'hFFFFFFFF, 5'd1, 5'd2);
    for (int t = 0; t < 10; t++) begin
      #10;
      check($sformatf("hold%0d rd1", t), rd1, 32'h0000000A);
      check($sformatf("hold%0d rd2", t), rd2, 32'h0000000B);
    end

    // x0 write during and after
    @(negedge clk);
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    #1;
    check("x0 during", rd1, 32'h0);
    @(posedge clk);
    #1;
    check("x0 after", rd1, 32'h0);

    // bypass stable across the edge
    @(negedge clk);
    drive(1'b1, 5'd7, 32'h0BADC0DE, 5'd7, 5'd7);
    #1;
    check("byp pre rd1", rd1, 32'h0BADC0DE);
    check("byp pre rd2", rd2, 32'h0BADC0DE);
    @(posedge clk);
    #1;
    check("byp edge rd1", rd1, 32'h0BADC0DE);
    wen = 1'b0;
    #1;
    check("byp post rd1", rd1, 32'h0BADC0DE);
    check("byp post rd2", rd2, 32'h0BADC0DE);

    // async reset mid-cycle, write attempted during reset
    @(negedge clk);
    drive(1'b1, 5'd1, 32'h0000000A, 5'd1, 5'd31);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd31);
    #1;
    check("pre-rst rd1", rd1, 32'h0000000A);
    check("pre-rst rd2", rd2, 32'h80000001);
    #1;
    rst = 1'b1;
    #1;
    check("rst async rd1", rd1, 32'h0);
    check("rst async rd2", rd2, 32'h0);
    drive(1'b1, 5'd9, 32'h99999999, 5'd9, 5'd31);
    #1;
    check("rst byp rd1", rd1, 32'h0);
    @(posedge clk);
    #1;
    check("rst write rd1", rd1, 32'h0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd31);
    rst = 1'b0;
    #1;
    check("post-rst r9", rd1, 32'h0);
    check("post-rst r31", rd2, 32'h0);
    rr1 = 5'd1;
    #1;
    check("post-rst r1", rd1, 32'h0);

    // full sweep
    model[0] = 32'h0;
    for (int i = 1; i < 32; i++) begin
      model[i] = i * 32'h01010101;
      @(negedge clk);
      drive(1'b1, i[4:0], model[i], 5'd0, 5'd0);
    end
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      rr1 = i[4:0];
      rr2 = 5'(31 - i);
      exp_q.push_back(model[i]);
      exp_q.push_back(model[31 - i]);
      #1;
      check_q($sformatf("sweep%0d rd1", i), rd1);
      check_q($sformatf("sweep%0d rd2", i), rd2);
    end

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
